// File: rtl/sram_blwl_prog_ctrl.sv
// Row-at-a-time programming sequencer for a bank of sram6T_blwl cells: drives
// bl/blb from each accepted row and pulses that row's word line (setup/pulse/hold).
module sram_blwl_prog_ctrl #(
  parameter int NUM_BL    = 8,
  parameter int NUM_WL    = 4,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1,
  localparam int ROW_W    = $clog2(NUM_WL)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [NUM_BL-1:0] cfg_data,
  output logic [NUM_BL-1:0] bl,
  output logic [NUM_BL-1:0] blb,
  output logic [NUM_WL-1:0] wl,
  output logic [ROW_W-1:0]  row,
  output logic              busy,
  output logic              done
);

  localparam int MAX_CYC = (SETUP_CYC > PULSE_CYC)
                           ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                           : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(NUM_WL - 1);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic                done_q, done_d;
  logic [NUM_BL-1:0]   bl_q, bl_d, blb_q, blb_d;
  logic [NUM_WL-1:0]   wl_q, wl_d;
  logic                transfer;

  // Gated by rst_n so the source never sees ready while the array is held in reset.
  assign cfg_ready = rst_n && (state_q == IDLE) && !done_q;
  // start has priority over a simultaneous transfer.
  assign transfer  = cfg_valid && cfg_ready && !start;

  assign bl   = bl_q;
  assign blb  = blb_q;
  assign wl   = wl_q;
  assign row  = row_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    done_d  = done_q;
    bl_d    = bl_q;
    blb_d   = blb_q;
    wl_d    = wl_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          row_d  = '0;
          done_d = 1'b0;
        end else if (transfer) begin
          bl_d    = cfg_data;
          blb_d   = ~cfg_data;
          cnt_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          wl_d    = NUM_WL'(1) << row_q;
          state_d = PULSE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = '0;
          wl_d    = '0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          bl_d    = '0;
          blb_d   = '0;
          state_d = IDLE;
          if (row_q == ROW_LAST) done_d = 1'b1;
          else                   row_d  = row_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        wl_d    = '0;
        bl_d    = '0;
        blb_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Async reset drops wl immediately, even mid-pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
      bl_q    <= '0;
      blb_q   <= '0;
      wl_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      done_q  <= done_d;
      bl_q    <= bl_d;
      blb_q   <= blb_d;
      wl_q    <= wl_d;
    end
  end

endmodule

// File: tb/tb_sram_blwl_prog_ctrl.sv
// Directed bench for sram_blwl_prog_ctrl with a behavioural cell array and
// per-cycle invariant monitor.
module tb_sram_blwl_prog_ctrl;

  localparam int NBL = 4;
  localparam int NWL = 3;
  localparam int RW  = $clog2(NWL);

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [NBL-1:0] cfg_data;
  logic [NBL-1:0] bl, blb;
  logic [NWL-1:0] wl;
  logic [RW-1:0]  row;
  logic           busy;
  logic           done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sram_blwl_prog_ctrl #(
    .NUM_BL(NBL), .NUM_WL(NWL), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_data(cfg_data), .bl(bl), .blb(blb),
    .wl(wl), .row(row), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Behavioural sram6T_blwl columns: a high word line writes bl into that row.
  logic [NBL-1:0] cells [NWL];
  logic           cell_clr = 1'b0;
  always @(negedge clk) begin
    for (int r = 0; r < NWL; r++) begin
      if (cell_clr)   cells[r] = '0;
      else if (wl[r]) cells[r] = bl;
    end
  end

  // Invariants sampled mid-cycle.
  logic [NWL-1:0] prev_wl = '0;
  logic [NBL-1:0] prev_bl = '0, prev_blb = '0, nbl;
  always @(negedge clk) begin
    if (rst_n) begin
      nbl = ~bl;
      check("inv_onehot0", 32'($onehot0(wl)), 1);
      if (busy) check("inv_blb_inv", blb, nbl);
      else      check("inv_idle_zero", {bl, blb, wl}, 0);
      if (|wl && |prev_wl) check("inv_bl_stable", {bl, blb}, {prev_bl, prev_blb});
    end
    prev_wl  = rst_n ? wl : '0;
    prev_bl  = bl;
    prev_blb = blb;
  end

  logic [NBL-1:0] rows [3];
  logic [NWL-1:0] wl_exp;

  initial begin
    rows      = '{4'hA, 4'h5, 4'h3};
    rst_n     = 1'b0;
    start     = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    #1;
    check("rst_outputs", {bl, blb, wl, row, busy, done}, 0);
    check("rst_ready", cfg_ready, 0);
    tick(2);
    rst_n = 1'b1;
    #1;
    check("rst_rel_ready", cfg_ready, 1);

    // 1: single row 1010
    cfg_valid = 1'b1;
    cfg_data  = 4'b1010;
    tick();
    cfg_valid = 1'b0;
    check("t1_bl_T1", bl, 4'b1010);
    check("t1_blb_T1", blb, 4'b0101);
    check("t1_wl_T1", wl, 3'b000);
    check("t1_busy_T1", busy, 1);
    tick();
    check("t1_wl_T2", wl, 3'b001);
    tick();
    check("t1_wl_T3", wl, 3'b001);
    tick();
    check("t1_wl_T4", wl, 3'b000);
    check("t1_bl_T4", {bl, blb}, {4'b1010, 4'b0101});
    tick();
    check("t1_idle_T5", {busy, bl, blb}, 0);
    check("t1_row_T5", row, 1);
    check("t1_ready_T5", cfg_ready, 1);

    // 2: three back-to-back rows with valid held
    start    = 1'b1;
    cell_clr = 1'b1;
    tick();
    start    = 1'b0;
    cell_clr = 1'b0;
    check("t2_start_row", row, 0);
    check("t2_start_done", done, 0);
    cfg_valid = 1'b1;
    cfg_data  = rows[0];
    for (int k = 0; k < 3; k++) begin
      wl_exp = NWL'(1) << k;
      tick();
      if (k < 2) cfg_data = rows[k+1];
      check($sformatf("t2_bl_r%0d", k), bl, rows[k]);
      tick();
      check($sformatf("t2_wl_r%0d_a", k), wl, wl_exp);
      tick();
      check($sformatf("t2_wl_r%0d_b", k), wl, wl_exp);
      tick();
      check($sformatf("t2_wl_r%0d_off", k), wl, 0);
      tick();
      if (k < 2) begin
        check($sformatf("t2_ready_r%0d", k), {cfg_ready, busy, done}, 3'b100);
      end else begin
        check("t2_done", done, 1);
        check("t2_ready_off", cfg_ready, 0);
        check("t2_row_last", row, 2);
      end
    end
    for (int r = 0; r < 3; r++) check($sformatf("t2_cell_%0d", r), cells[r], rows[r]);

    // 3: valid while done is held off; start reopens the sequence
    cfg_data = 4'hF;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t3_held_off", {busy, wl, bl, blb, cfg_ready}, 0);
    end
    check("t3_state_kept", {done, row}, {1'b1, 2'd2});
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t3_start_wins", {busy, done, row}, 0);
    check("t3_ready_again", cfg_ready, 1);
    tick();
    cfg_valid = 1'b0;
    check("t3_bl", bl, 4'hF);
    tick();
    check("t3_wl", wl, 3'b001);
    tick(3);
    check("t3_row_next", {busy, row}, {1'b0, 2'd1});

    // 4: start during PULSE of row 1 is ignored
    cfg_valid = 1'b1;
    cfg_data  = 4'h6;
    tick();
    cfg_valid = 1'b0;
    tick();
    check("t4_wl_a", wl, 3'b010);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_wl_b", wl, 3'b010);
    tick();
    check("t4_wl_off", wl, 0);
    tick();
    check("t4_row", {busy, done, row}, {1'b0, 1'b0, 2'd2});

    // 5: async reset mid-PULSE
    cfg_valid = 1'b1;
    cfg_data  = 4'h9;
    tick();
    cfg_valid = 1'b0;
    tick();
    check("t5_wl_pre", wl, 3'b100);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_clear", {wl, bl, blb, busy}, 0);
    check("t5_ready_rst", cfg_ready, 0);
    tick(2);
    rst_n = 1'b1;
    #1;
    check("t5_post_row_done", {row, done}, 0);
    check("t5_post_ready", cfg_ready, 1);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
